// File: rtl/param_fifo_if.sv
// Handshake and status bundle between a producer/consumer stage and param_fifo.
// The FIFO takes the slave side; the stage driving writes/reads takes the master side.
interface param_fifo_if #(
  parameter int ITEM_SIZE_BITS = 32,
  parameter int FIFO_SIZE      = 10
);
  localparam int COUNT_BITS = $clog2(FIFO_SIZE + 1);

  logic                      flush;
  logic [ITEM_SIZE_BITS-1:0] data_in;
  logic                      write;
  logic                      read;
  logic                      clear_errors;
  logic [ITEM_SIZE_BITS-1:0] data_out;
  logic                      empty;
  logic                      full;
  logic                      almost_empty;
  logic                      almost_full;
  logic [COUNT_BITS-1:0]     count;
  logic                      overflow;
  logic                      underflow;

  modport master (
    output flush, data_in, write, read, clear_errors,
    input  data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  flush, data_in, write, read, clear_errors,
    output data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/param_fifo.sv
// Single-clock FIFO of any depth >= 2 with standard or first-word-fall-through reads,
// programmable almost flags, synchronous flush and sticky overflow/underflow errors.
module param_fifo #(
  parameter int ITEM_SIZE_BITS     = 32,
  parameter int FIFO_SIZE          = 10,
  parameter int FWFT               = 0,
  parameter int ALMOST_FULL_LEVEL  = FIFO_SIZE - 2,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input logic         clk,
  input logic         rst,
  param_fifo_if.slave bus
);
  localparam int PTR_BITS   = $clog2(FIFO_SIZE);
  localparam int COUNT_BITS = $clog2(FIFO_SIZE + 1);

  logic [ITEM_SIZE_BITS-1:0] items [FIFO_SIZE];
  logic [PTR_BITS-1:0]       wr_ptr;
  logic [PTR_BITS-1:0]       rd_ptr;
  logic [COUNT_BITS-1:0]     count_q;
  logic [ITEM_SIZE_BITS-1:0] data_q;
  logic                      overflow_q;
  logic                      underflow_q;

  logic empty_w;
  logic full_w;
  logic rd_ok;
  logic wr_ok;
  logic overflow_set;
  logic underflow_set;

  // Depth need not be a power of two, so wrap is an explicit compare.
  function automatic logic [PTR_BITS-1:0] next_ptr(input logic [PTR_BITS-1:0] p);
    return (p == PTR_BITS'(FIFO_SIZE - 1)) ? '0 : p + PTR_BITS'(1);
  endfunction

  assign empty_w       = (count_q == '0);
  assign full_w        = (count_q == COUNT_BITS'(FIFO_SIZE));
  assign rd_ok         = bus.read & ~empty_w;
  assign wr_ok         = bus.write & (~full_w | rd_ok);
  assign overflow_set  = bus.write & ~wr_ok;
  assign underflow_set = bus.read & empty_w;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      data_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (wr_ok) wr_ptr <= next_ptr(wr_ptr);
        if (rd_ok) rd_ptr <= next_ptr(rd_ptr);
        case ({wr_ok, rd_ok})
          2'b10:   count_q <= count_q + COUNT_BITS'(1);
          2'b01:   count_q <= count_q - COUNT_BITS'(1);
          default: count_q <= count_q;
        endcase
        if ((FWFT == 0) && rd_ok) data_q <= items[rd_ptr];
      end
      // A new error in the same cycle as clear_errors must survive the clear.
      overflow_q  <= overflow_set | (overflow_q & ~bus.clear_errors);
      underflow_q <= underflow_set | (underflow_q & ~bus.clear_errors);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !bus.flush) items[wr_ptr] <= bus.data_in;
  end

  assign bus.data_out     = (FWFT != 0) ? (empty_w ? '0 : items[rd_ptr]) : data_q;
  assign bus.empty        = empty_w;
  assign bus.full         = full_w;
  assign bus.almost_empty = (int'(count_q) <= ALMOST_EMPTY_LEVEL);
  assign bus.almost_full  = (int'(count_q) >= ALMOST_FULL_LEVEL);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule
